// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte assembler.
// SYNC_BYTE is the SYNC pattern as it appears after LSB-first assembly.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } rx_asm_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

endpackage

// File: rtl/rx_shift_reg.sv
// 8-bit LSB-first deserialiser: new bits enter at the MSB and move toward bit 0.
// Clear has priority over shift.
module rx_shift_reg (
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       d_i,
  output logic [7:0] q_o
);

  logic [7:0] sr_q;

  // shift register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      sr_q <= 8'h00;
    end else if (shift_i) begin
      sr_q <= {d_i, sr_q[7:1]};
    end else begin
      sr_q <= sr_q;
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/rx_byte_assembler.sv
// Frames the unstuffed USB bit stream into bytes, checks SYNC and reports
// byte strobes, packet end and framing errors to the RX control FSM.
module rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_PAT = SYNC_BYTE,
  parameter int unsigned CNT_W    = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_unstuffed_i,
  input  logic             shift_enable_i,
  input  logic             unstuff_hold_i,
  input  logic             eop_i,
  output logic [7:0]       rx_data_o,
  output logic             byte_ready_o,
  output logic             sync_found_o,
  output logic             packet_done_o,
  output logic             rx_error_o,
  output logic [CNT_W-1:0] byte_count_o
);

  rx_asm_state_t    state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             eop_seen_q, eop_seen_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             byte_ready_q, byte_ready_d;
  logic             sync_found_q, sync_found_d;
  logic             packet_done_q, packet_done_d;
  logic             rx_error_q, rx_error_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;

  logic       accept_s;
  logic       sr_shift_s;
  logic       sr_clear_s;
  logic [7:0] sr_s;
  logic [7:0] new_byte_s;

  // eop outranks the strobe; a stuffed bit is never shifted in
  assign accept_s   = shift_enable_i & ~unstuff_hold_i & ~eop_i;
  assign new_byte_s = {d_unstuffed_i, sr_s[7:1]};

  rx_shift_reg u_shift_reg (
    .clk_i   (clk_i),
    .clear_i (rst_i | sr_clear_s),
    .shift_i (sr_shift_s),
    .d_i     (d_unstuffed_i),
    .q_o     (sr_s)
  );

  // next-state, counters and registered output values
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    eop_seen_d    = 1'b0;
    rx_data_d     = rx_data_q;
    byte_ready_d  = 1'b0;
    sync_found_d  = 1'b0;
    packet_done_d = 1'b0;
    rx_error_d    = rx_error_q;
    byte_count_d  = byte_count_q;
    sr_shift_s    = 1'b0;
    sr_clear_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d    = SYNC;
          sr_shift_s = 1'b1;
          bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        if (eop_i) begin
          state_d    = ERR;
          rx_error_d = 1'b1;
          eop_seen_d = 1'b1;
        end else if (accept_s) begin
          sr_shift_s = 1'b1;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (new_byte_s == SYNC_PAT) begin
              state_d      = DATA;
              sync_found_d = 1'b1;
              rx_error_d   = 1'b0;
              byte_count_d = '0;
            end else begin
              state_d    = ERR;
              rx_error_d = 1'b1;
            end
          end else begin
            state_d = SYNC;
          end
        end else begin
          state_d = SYNC;
        end
      end
      DATA: begin
        if (eop_i) begin
          if (bit_cnt_q == 3'd0) begin
            state_d       = DONE;
            packet_done_d = 1'b1;
          end else begin
            state_d    = ERR;
            rx_error_d = 1'b1;
            eop_seen_d = 1'b1;
          end
        end else if (accept_s) begin
          sr_shift_s = 1'b1;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d    = new_byte_s;
            byte_ready_d = 1'b1;
            if (byte_count_q != {CNT_W{1'b1}}) begin
              byte_count_d = byte_count_q + CNT_W'(1);
            end else begin
              byte_count_d = byte_count_q;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        if (!eop_i) begin
          state_d    = IDLE;
          sr_clear_s = 1'b1;
          bit_cnt_d  = 3'd0;
        end else begin
          state_d = DONE;
        end
      end
      ERR: begin
        // the SE0 that ends the broken packet must be seen high before we re-arm
        eop_seen_d = eop_seen_q | eop_i;
        if (eop_seen_q && !eop_i) begin
          state_d    = IDLE;
          sr_clear_s = 1'b1;
          bit_cnt_d  = 3'd0;
          eop_seen_d = 1'b0;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        state_d    = IDLE;
        sr_clear_s = 1'b1;
        bit_cnt_d  = 3'd0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      eop_seen_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      byte_ready_q  <= 1'b0;
      sync_found_q  <= 1'b0;
      packet_done_q <= 1'b0;
      rx_error_q    <= 1'b0;
      byte_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      eop_seen_q    <= eop_seen_d;
      rx_data_q     <= rx_data_d;
      byte_ready_q  <= byte_ready_d;
      sync_found_q  <= sync_found_d;
      packet_done_q <= packet_done_d;
      rx_error_q    <= rx_error_d;
      byte_count_q  <= byte_count_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign byte_ready_o  = byte_ready_q;
  assign sync_found_o  = sync_found_q;
  assign packet_done_o = packet_done_q;
  assign rx_error_o    = rx_error_q;
  assign byte_count_o  = byte_count_q;

endmodule
